switch_debouncer: RTL and testbench
===================================

Name: switch_debouncer

Overview:
- Conditions the 8 raw slide-switch inputs before they drive the Binary-to-BCD display path (two's complement, then BCD conversion, then seven-segment decoding).
- Each switch is synchronised into the clock domain with a 2-FF synchroniser.
- Contact bounce is rejected by requiring the whole vector to hold constant for a programmable number of cycles.
- Outputs a clean registered vector and a one-cycle change strobe.
- Sits directly upstream of the Switchs input of the display top.

Parameters:
WIDTH, 8, number of switch bits.
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new value (10 ms at 50 MHz); legal range ≥2.
CNT_W, $clog2(DEBOUNCE_CYCLES), settle-counter width; derived, not overridden.

Ports:
clk  in  1  system clock, rising-edge.
rst_n  in  1  asynchronous active-low reset.
switches_raw  in  WIDTH  asynchronous switch levels.
switches_stable  out  WIDTH  debounced value; feeds the display-path Switchs input.
value_changed  out  1  one-cycle pulse when switches_stable takes a new, different value.
bouncing  out  1  high while the FSM is in SETTLING.

Behaviour:
- One clock domain. Reset is asynchronous and active-low; it is asserted and released only through rst_n.
- Reset values (all outputs and state): sync_q1 = 0, sync_q2 = 0, candidate = 0, cnt = 0, state = STABLE, switches_stable = 0, value_changed = 0, bouncing = 0.
- Synchroniser: sync_q1 <= switches_raw and sync_q2 <= sync_q1 every edge. The FSM uses only sync_q2; raw inputs never reach logic directly.
- FSM states: STABLE, SETTLING.
- STABLE, sync_q2 == switches_stable: stay in STABLE; cnt holds 0.
- STABLE, sync_q2 != switches_stable: go to SETTLING; candidate <= sync_q2; cnt <= 0.
- SETTLING, sync_q2 != candidate (any bit): restart. candidate <= sync_q2, cnt <= 0, stay in SETTLING.
- SETTLING, sync_q2 == candidate and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
- SETTLING, sync_q2 == candidate and cnt == DEBOUNCE_CYCLES-1 (expiry): go to STABLE and cnt <= 0.
  - If candidate != switches_stable: switches_stable <= candidate and value_changed <= 1 for exactly the next cycle.
  - If candidate == switches_stable (glitch returned to the old value): no update, no pulse.
- Latency: after a clean raw change settling before clock edge e1, switches_stable updates at edge e(DEBOUNCE_CYCLES+3), i.e. 2 synchroniser edges + 1 entry edge + DEBOUNCE_CYCLES counting edges. value_changed is high in the cycle following that edge.
- Debounce scope: bounce is tracked per vector, not per bit. A change on any bit restarts the count for all bits. Simultaneous multi-bit changes are accepted as one update with one pulse.
- Outputs are registered; there is no combinational path from switches_raw to any output.
- bouncing = (state == SETTLING), registered with the state.
- cnt never exceeds DEBOUNCE_CYCLES-1; it does not wrap.
- Reset mid-operation:
  - Asynchronous assertion immediately forces the reset values, abandons any SETTLING in progress and suppresses any pending pulse.
  - After release, a non-zero switch vector is debounced from scratch and produces one value_changed pulse.
- value_changed never asserts on two consecutive cycles. Minimum pulse spacing is DEBOUNCE_CYCLES+1 cycles.

Test Plan:
(WIDTH = 8, DEBOUNCE_CYCLES = 4 for all scenarios)
1. Reset with raw = 8'hA5, release, hold → switches_stable = 8'h00 and bouncing = 0 during reset; after release, switches_stable = 8'hA5 at edge 7, single value_changed pulse, bouncing high for edges 3–6 then low.
2. From stable 8'h00, raw toggles 8'h00/8'h01 every 2 cycles for 20 cycles, then holds 8'h01 → no update and no pulse during toggling; switches_stable = 8'h01 exactly 7 edges after the last transition, one pulse.
3. From stable 8'h3C, raw glitches to 8'h3D for 1 cycle and then returns → SETTLING entered and exited; switches_stable stays 8'h3C; value_changed stays 0.
4. From stable 8'h00, raw = 8'hFF (all bits simultaneously) → single update to 8'hFF, exactly one pulse, latency 7 edges.
5. rst_n asserted asynchronously mid-SETTLING (cnt = 2, candidate = 8'h80) → outputs 8'h00/0/0 immediately without a clock edge; after release with raw = 8'h80, 8'h80 accepted 7 edges later with one pulse.
6. Sweep raw through 8'h00 → 8'h7F → 8'h80 → 8'hFF, each held 10 cycles → switches_stable follows each value with 7-edge latency, four pulses, and pulses never adjacent.

Source files
------------

// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: 2-FF synchroniser followed by a whole-vector debounce FSM.
// Produces a registered clean vector, a one-cycle change strobe and a settling flag.
module switch_debouncer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] switches_raw,
    output logic [WIDTH-1:0] switches_stable,
    output logic             value_changed,
    output logic             bouncing
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // state    | meaning
    // STABLE   | sync_q2 matches switches_stable, counter idle at 0
    // SETTLING | a different value was seen; counting consecutive matches of candidate
    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] sync_q1, sync_q2;
    logic [WIDTH-1:0] candidate, candidate_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] stable_next;
    logic             changed_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= switches_raw;
            sync_q2 <= sync_q1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= STABLE;
            candidate       <= '0;
            cnt             <= '0;
            switches_stable <= '0;
            value_changed   <= 1'b0;
            bouncing        <= 1'b0;
        end else begin
            state           <= state_next;
            candidate       <= candidate_next;
            cnt             <= cnt_next;
            switches_stable <= stable_next;
            value_changed   <= changed_next;
            bouncing        <= (state_next == SETTLING);
        end
    end

    always_comb begin
        state_next     = state;
        candidate_next = candidate;
        cnt_next       = cnt;
        stable_next    = switches_stable;
        changed_next   = 1'b0;

        case (state)
            STABLE: begin
                cnt_next = '0;
                if (sync_q2 != switches_stable) begin
                    state_next     = SETTLING;
                    candidate_next = sync_q2;
                end
            end
            SETTLING: begin
                // Any bit moving restarts the whole vector's count.
                if (sync_q2 != candidate) begin
                    candidate_next = sync_q2;
                    cnt_next       = '0;
                end else if (cnt != CNT_LAST) begin
                    cnt_next = cnt + CNT_W'(1);
                end else begin
                    state_next = STABLE;
                    cnt_next   = '0;
                    // A glitch that settled back onto the old value is silent.
                    if (candidate != switches_stable) begin
                        stable_next  = candidate;
                        changed_next = 1'b1;
                    end
                end
            end
        endcase
    end

    cnt_in_range: assert property (@(posedge clk) disable iff (!rst_n) cnt <= CNT_LAST);
    no_back_to_back_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        value_changed |=> !value_changed);

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with DEBOUNCE_CYCLES = 4 (7-edge accept latency).
// Table-driven reset/accept vectors plus hand-written bounce, glitch, reset and sweep sequences.
module tb_switch_debouncer;

    localparam int WIDTH = 8;
    localparam int DC    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] switches_raw;
    logic [WIDTH-1:0] switches_stable;
    logic             value_changed;
    logic             bouncing;

    switch_debouncer #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .switches_raw   (switches_raw),
        .switches_stable(switches_stable),
        .value_changed  (value_changed),
        .bouncing       (bouncing)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] raw;
        logic [7:0] stable;
        logic       changed;
        logic       bouncing;
    } vec_t;

    vec_t       tbl [27];
    int         checks   = 0;
    int         failures = 0;
    int         pulses   = 0;
    logic       prev_vc  = 1'b0;
    logic [7:0] cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] v);
        switches_raw = v;
        @(posedge clk);
        #1;
    endtask

    // Drive v for n edges; the first edge is e1 of the change.
    task automatic hold(input logic [7:0] v, input int n, input string tag);
        logic diff;
        diff = (v != cur);
        for (int k = 1; k <= n; k++) begin
            step(v);
            if (diff) begin
                chk($sformatf("%s_stable_k%0d", tag, k), switches_stable, (k >= 7) ? v : cur);
                chk($sformatf("%s_changed_k%0d", tag, k), value_changed, (k == 7));
                if (k >= 3)
                    chk($sformatf("%s_bouncing_k%0d", tag, k), bouncing, (k <= 6));
            end else begin
                chk($sformatf("%s_stable_k%0d", tag, k), switches_stable, cur);
                chk($sformatf("%s_changed_k%0d", tag, k), value_changed, 0);
                chk($sformatf("%s_bouncing_k%0d", tag, k), bouncing, 0);
            end
        end
        if (diff && n >= 7) cur = v;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (value_changed === 1'b1) pulses++;
            chk("no_adjacent_pulse", {31'b0, value_changed & prev_vc}, 0);
            prev_vc = value_changed;
        end else begin
            prev_vc = 1'b0;
        end
    end

    initial begin
        int         p0;
        logic       saw_b;
        logic [7:0] sweep [4];

        tbl[0]  = '{8'hA5, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{8'hA5, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{8'hA5, 8'h00, 1'b0, 1'b1};
        tbl[3]  = '{8'hA5, 8'h00, 1'b0, 1'b1};
        tbl[4]  = '{8'hA5, 8'h00, 1'b0, 1'b1};
        tbl[5]  = '{8'hA5, 8'h00, 1'b0, 1'b1};
        tbl[6]  = '{8'hA5, 8'hA5, 1'b1, 1'b0};
        tbl[7]  = '{8'hA5, 8'hA5, 1'b0, 1'b0};
        tbl[8]  = '{8'hA5, 8'hA5, 1'b0, 1'b0};
        tbl[9]  = '{8'h00, 8'hA5, 1'b0, 1'b0};
        tbl[10] = '{8'h00, 8'hA5, 1'b0, 1'b0};
        tbl[11] = '{8'h00, 8'hA5, 1'b0, 1'b1};
        tbl[12] = '{8'h00, 8'hA5, 1'b0, 1'b1};
        tbl[13] = '{8'h00, 8'hA5, 1'b0, 1'b1};
        tbl[14] = '{8'h00, 8'hA5, 1'b0, 1'b1};
        tbl[15] = '{8'h00, 8'h00, 1'b1, 1'b0};
        tbl[16] = '{8'h00, 8'h00, 1'b0, 1'b0};
        tbl[17] = '{8'h00, 8'h00, 1'b0, 1'b0};
        tbl[18] = '{8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[19] = '{8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[20] = '{8'hFF, 8'h00, 1'b0, 1'b1};
        tbl[21] = '{8'hFF, 8'h00, 1'b0, 1'b1};
        tbl[22] = '{8'hFF, 8'h00, 1'b0, 1'b1};
        tbl[23] = '{8'hFF, 8'h00, 1'b0, 1'b1};
        tbl[24] = '{8'hFF, 8'hFF, 1'b1, 1'b0};
        tbl[25] = '{8'hFF, 8'hFF, 1'b0, 1'b0};
        tbl[26] = '{8'hFF, 8'hFF, 1'b0, 1'b0};

        // Reset held with a non-zero raw vector.
        rst_n        = 1'b0;
        switches_raw = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rst_stable_%0d", i), switches_stable, 8'h00);
            chk($sformatf("rst_changed_%0d", i), value_changed, 0);
            chk($sformatf("rst_bouncing_%0d", i), bouncing, 0);
        end
        rst_n = 1'b1;

        // Accept A5 after release, then 00, then all bits at once to FF.
        for (int i = 0; i < 27; i++) begin
            step(tbl[i].raw);
            chk($sformatf("tbl%0d_stable", i), switches_stable, tbl[i].stable);
            chk($sformatf("tbl%0d_changed", i), value_changed, tbl[i].changed);
            chk($sformatf("tbl%0d_bouncing", i), bouncing, tbl[i].bouncing);
        end
        chk("tbl_pulses", pulses, 3);
        cur = 8'hFF;

        // Bounce 00/01 every 2 cycles, then settle on 01.
        hold(8'h00, 10, "pre_bounce");
        p0 = pulses;
        for (int i = 0; i < 20; i++) begin
            step(((i / 2) % 2 == 0) ? 8'h01 : 8'h00);
            chk($sformatf("bounce_stable_%0d", i), switches_stable, 8'h00);
            chk($sformatf("bounce_changed_%0d", i), value_changed, 0);
        end
        chk("bounce_still_settling", bouncing, 1);
        hold(8'h01, 9, "bounce_settle");
        chk("bounce_pulses", pulses - p0, 1);

        // One-cycle glitch that returns to the old value.
        hold(8'h3C, 10, "pre_glitch");
        p0    = pulses;
        saw_b = 1'b0;
        step(8'h3D);
        chk("glitch_stable_0", switches_stable, 8'h3C);
        for (int i = 1; i <= 10; i++) begin
            step(8'h3C);
            if (bouncing) saw_b = 1'b1;
            chk($sformatf("glitch_stable_%0d", i), switches_stable, 8'h3C);
            chk($sformatf("glitch_changed_%0d", i), value_changed, 0);
        end
        chk("glitch_entered_settling", saw_b, 1);
        chk("glitch_exited_settling", bouncing, 0);
        chk("glitch_pulses", pulses - p0, 0);

        // Asynchronous reset while settling on 80 with cnt = 2.
        hold(8'h00, 10, "pre_rst");
        for (int k = 1; k <= 5; k++) step(8'h80);
        chk("mid_settle_bouncing", bouncing, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_stable", switches_stable, 8'h00);
        chk("async_rst_changed", value_changed, 0);
        chk("async_rst_bouncing", bouncing, 0);
        @(posedge clk);
        #1;
        chk("async_rst_hold_bouncing", bouncing, 0);
        rst_n = 1'b1;
        cur   = 8'h00;
        p0    = pulses;
        hold(8'h80, 9, "rst_recover");
        chk("rst_recover_pulses", pulses - p0, 1);

        // Sweep through four values, 10 cycles each.
        sweep[0] = 8'h00;
        sweep[1] = 8'h7F;
        sweep[2] = 8'h80;
        sweep[3] = 8'hFF;
        p0 = pulses;
        for (int i = 0; i < 4; i++)
            hold(sweep[i], 10, $sformatf("sweep%0d", i));
        chk("sweep_pulses", pulses - p0, 4);
        chk("sweep_final", switches_stable, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
